// File: rtl/sysarray_pkg.sv
// sysarray_pkg: shared constants, FSM state enum and operand/result types
// for the 3x3 systolic array job sequencer.
package sysarray_pkg;

  localparam int N        = 3;
  localparam int FEED_CYC = 2 * N - 1;

  localparam int A_BITS   = 8;
  localparam int B_BITS   = 8;
  localparam int ACC_BITS = 18;
  localparam int CNT_BITS = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } ctrl_state_e;

  typedef logic signed [A_BITS-1:0]   a_el_t;
  typedef logic signed [B_BITS-1:0]   b_el_t;
  typedef logic signed [ACC_BITS-1:0] acc_el_t;

  typedef a_el_t   [0:N-1][0:N-1] a_mat_t;
  typedef b_el_t   [0:N-1][0:N-1] b_mat_t;
  typedef acc_el_t [0:N-1][0:N-1] res_mat_t;

endpackage

// File: rtl/sysarray_ctrl_if.sv
// sysarray_ctrl_if: host-side job and result handshakes.
// master = host (offers jobs, consumes results), slave = controller.
interface sysarray_ctrl_if;
  import sysarray_pkg::*;

  logic                job_valid;
  logic                job_ready;
  logic                job_acc;
  a_mat_t              a_mat;
  b_mat_t              b_mat;
  logic                res_valid;
  logic                res_ready;
  res_mat_t            res;
  logic                busy;
  logic [CNT_BITS-1:0] job_cnt;

  modport master (
    output job_valid, job_acc, a_mat, b_mat, res_ready,
    input  job_ready, res_valid, res, busy, job_cnt
  );

  modport slave (
    input  job_valid, job_acc, a_mat, b_mat, res_ready,
    output job_ready, res_valid, res, busy, job_cnt
  );

endinterface

// File: rtl/sysarray_skew.sv
// sysarray_skew: feed index -> diagonally skewed left/top edge vectors.
// Ports: i_idx feed step, i_a/i_b operands, o_left/o_top edge values.
module sysarray_skew
  import sysarray_pkg::*;
#(
  parameter int A_W = A_BITS,
  parameter int B_W = B_BITS
) (
  input  logic [2:0]                    i_idx,
  input  logic [0:N-1][0:N-1][A_W-1:0] i_a,
  input  logic [0:N-1][0:N-1][B_W-1:0] i_b,
  output logic [0:N-1][A_W-1:0]        o_left,
  output logic [0:N-1][B_W-1:0]        o_top
);

  // Row/column i sees element k when idx = i + k.
  always_comb begin
    o_left = '0;
    o_top  = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (int'(i_idx) == i + k) begin
          o_left[i] = i_a[i][k];
          o_top[i]  = i_b[k][i];
        end
      end
    end
  end

endmodule

// File: rtl/sysarray_ctrl.sv
// sysarray_ctrl: clear / skewed feed / drain / capture sequencer.
// Ports: clk, rst_n, host (job+result), sa_clr/sa_left/sa_top out, sa_out in.
module sysarray_ctrl
  import sysarray_pkg::*;
#(
  parameter int A_W       = A_BITS,
  parameter int B_W       = B_BITS,
  parameter int ACC_W     = ACC_BITS,
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = CNT_BITS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  sysarray_ctrl_if.slave                  host,
  output logic                            sa_clr,
  output logic [0:N-1][A_W-1:0]           sa_left,
  output logic [0:N-1][B_W-1:0]           sa_top,
  input  logic [0:N-1][0:N-1][ACC_W-1:0]  sa_out
);

  localparam logic [2:0] ST_IDLE  = 3'(S_IDLE);
  localparam logic [2:0] ST_CLEAR = 3'(S_CLEAR);
  localparam logic [2:0] ST_FEED  = 3'(S_FEED);
  localparam logic [2:0] ST_DRAIN = 3'(S_DRAIN);
  localparam logic [2:0] ST_DONE  = 3'(S_DONE);

  localparam int DC_W = $clog2(DRAIN_CYC) + 1;

  logic [2:0]                      r_state;
  logic [2:0]                      r_fcnt;
  logic [DC_W-1:0]                 r_dcnt;
  logic [0:N-1][0:N-1][A_W-1:0]    r_a;
  logic [0:N-1][0:N-1][B_W-1:0]    r_b;
  logic                            r_clr;
  logic [0:N-1][A_W-1:0]           r_left;
  logic [0:N-1][B_W-1:0]           r_top;
  logic [0:N-1][0:N-1][ACC_W-1:0]  r_res;
  logic [CNT_W-1:0]                r_cnt;

  logic                            w_idle;
  logic [2:0]                      w_idx;
  logic [0:N-1][0:N-1][A_W-1:0]    w_a;
  logic [0:N-1][0:N-1][B_W-1:0]    w_b;
  logic [0:N-1][A_W-1:0]           w_left;
  logic [0:N-1][B_W-1:0]           w_top;

  assign w_idle = (r_state == ST_IDLE);

  // Edges are registered one step ahead: an accumulate job feeds
  // straight from the host operands on its acceptance edge.
  assign w_a   = w_idle ? host.a_mat : r_a;
  assign w_b   = w_idle ? host.b_mat : r_b;
  assign w_idx = (r_state == ST_FEED) ? r_fcnt + 3'd1 : 3'd0;

  sysarray_skew #(
    .A_W (A_W),
    .B_W (B_W)
  ) u_skew (
    .i_idx  (w_idx),
    .i_a    (w_a),
    .i_b    (w_b),
    .o_left (w_left),
    .o_top  (w_top)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_fcnt  <= '0;
      r_dcnt  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_clr   <= 1'b0;
      r_left  <= '0;
      r_top   <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
    end else begin
      r_clr  <= 1'b0;
      r_left <= '0;
      r_top  <= '0;
      unique case (1'b1)
        (r_state == ST_IDLE): begin
          if (host.job_valid) begin
            r_a <= host.a_mat;
            r_b <= host.b_mat;
            if (host.job_acc) begin
              r_state <= ST_FEED;
              r_fcnt  <= '0;
              r_left  <= w_left;
              r_top   <= w_top;
            end else begin
              r_state <= ST_CLEAR;
              r_clr   <= 1'b1;
            end
          end
        end
        (r_state == ST_CLEAR): begin
          r_state <= ST_FEED;
          r_fcnt  <= '0;
          r_left  <= w_left;
          r_top   <= w_top;
        end
        (r_state == ST_FEED): begin
          if (r_fcnt == 3'(FEED_CYC - 1)) begin
            r_state <= ST_DRAIN;
            r_dcnt  <= '0;
          end else begin
            r_fcnt <= r_fcnt + 3'd1;
            r_left <= w_left;
            r_top  <= w_top;
          end
        end
        (r_state == ST_DRAIN): begin
          if (r_dcnt == DC_W'(DRAIN_CYC - 1)) begin
            r_state <= ST_DONE;
            r_res   <= sa_out;
          end else begin
            r_dcnt <= r_dcnt + DC_W'(1);
          end
        end
        (r_state == ST_DONE): begin
          if (host.res_ready) begin
            r_state <= ST_IDLE;
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign host.job_ready = w_idle;
  assign host.busy      = !w_idle;
  assign host.res_valid = (r_state == ST_DONE);
  assign host.res       = r_res;
  assign host.job_cnt   = r_cnt;

  assign sa_clr  = r_clr;
  assign sa_left = r_left;
  assign sa_top  = r_top;

endmodule

// File: tb/tb_sysarray_ctrl.sv
// tb_sysarray_ctrl: random and directed jobs against a matrix-product model,
// with a behavioural 3x3 output-stationary array hooked to the edges.
module tb_sysarray_ctrl;
  import sysarray_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sysarray_ctrl_if hif ();

  logic                  sa_clr;
  logic [0:2][7:0]       sa_left;
  logic [0:2][7:0]       sa_top;
  logic [0:2][0:2][17:0] sa_out;

  sysarray_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .host    (hif),
    .sa_clr  (sa_clr),
    .sa_left (sa_left),
    .sa_top  (sa_top),
    .sa_out  (sa_out)
  );

  // Behavioural array: a moves right, b moves down, acc += a*b.
  logic signed [7:0]  pa  [3][3];
  logic signed [7:0]  pb  [3][3];
  logic signed [17:0] acc [3][3];

  initial begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        pa[i][j] = '0;
        pb[i][j] = '0;
        acc[i][j] = '0;
      end
  end

  function automatic logic signed [7:0] ain(int i, int j);
    if (j == 0) return sa_left[i];
    return pa[i][j-1];
  endfunction

  function automatic logic signed [7:0] bin(int i, int j);
    if (i == 0) return sa_top[j];
    return pb[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        pa[i][j] <= ain(i, j);
        pb[i][j] <= bin(i, j);
        acc[i][j] <= sa_clr ? 18'sd0 : acc[i][j] + ain(i, j) * bin(i, j);
      end
  end

  always_comb begin
    sa_out = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        sa_out[i][j] = acc[i][j];
  end

  int clr_cnt = 0;
  int clr_bad = 0;
  always @(negedge clk) begin
    if (sa_clr) clr_cnt++;
    if (sa_clr && (sa_left != '0 || sa_top != '0)) clr_bad++;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // kind 0: 1..9 row-major, 1: identity, 2: all v, else random
  function automatic a_mat_t mat(int kind, int v);
    a_mat_t m;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++) begin
        if (kind == 0)      m[i][k] = 8'(3 * i + k + 1);
        else if (kind == 1) m[i][k] = (i == k) ? 8'd1 : 8'd0;
        else if (kind == 2) m[i][k] = 8'(v);
        else                m[i][k] = 8'($urandom);
      end
    return m;
  endfunction

  function automatic res_mat_t matmul(a_mat_t a, a_mat_t b,
                                      res_mat_t c0, bit accum);
    res_mat_t c;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        int s;
        s = accum ? int'($signed(c0[i][j])) : 0;
        for (int k = 0; k < 3; k++)
          s += int'($signed(a[i][k])) * int'($signed(b[k][j]));
        c[i][j] = ACC_BITS'(s);
      end
    return c;
  endfunction

  res_mat_t    model_c = '0;
  res_mat_t    exp_c   = '0;
  bit          cur_acc = 1'b0;
  int          clr0    = 0;
  logic [15:0] exp_cnt = '0;

  task automatic accept(input a_mat_t a, input a_mat_t b, input bit accum);
    int w;
    w = 0;
    while (!hif.job_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk("ready_wait", hif.job_ready, 1);
    exp_c   = matmul(a, b, model_c, accum);
    cur_acc = accum;
    clr0    = clr_cnt;
    hif.a_mat     = a;
    hif.b_mat     = b;
    hif.job_acc   = accum;
    hif.job_valid = 1'b1;
    @(posedge clk); #1;
    hif.job_valid = 1'b0;
    hif.a_mat     = mat(3, 0);
    hif.b_mat     = mat(3, 0);
    hif.job_acc   = 1'($urandom);
  endtask

  task automatic finish_job(input int exp_lat, input int hold);
    int lat;
    lat = 0;
    while (!hif.res_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, exp_lat);
    chk("clr_pulses", clr_cnt - clr0, cur_acc ? 0 : 1);
    chk("res", hif.res, exp_c);
    chk("ready_done", hif.job_ready, 0);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    chk("res_hold", {hif.res_valid, hif.res}, {1'b1, exp_c});
    hif.res_ready = 1'b1;
    @(posedge clk); #1;
    hif.res_ready = 1'b0;
    exp_cnt++;
    chk("job_cnt", hif.job_cnt, exp_cnt);
    chk("back_idle", {hif.res_valid, hif.busy, hif.job_ready}, 3'b001);
    chk("res_kept", hif.res, exp_c);
    model_c = exp_c;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ctl"},
        {hif.job_ready, hif.busy, hif.res_valid, sa_clr}, 4'b1000);
    chk({tag, "_edges"}, {sa_left, sa_top}, '0);
    chk({tag, "_res"}, hif.res, '0);
    chk({tag, "_cnt"}, hif.job_cnt, 0);
  endtask

  initial begin
    bit stable;
    bit jr;
    bit have_prev;
    hif.job_valid = 1'b0;
    hif.job_acc   = 1'b0;
    hif.a_mat     = '0;
    hif.b_mat     = '0;
    hif.res_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // identity B returns A
    accept(mat(0, 0), mat(1, 0), 1'b0);
    finish_job(9, 2);

    // extreme signed operands
    accept(mat(2, 127), mat(2, -128), 1'b0);
    finish_job(9, 0);
    chk("neg_corner", {hif.res[1][2]}, {18'(-48768)});

    // K-tiling: second job accumulates onto the first
    accept(mat(2, 1), mat(2, 1), 1'b0);
    finish_job(9, 1);
    chk("ones", {hif.res[2][0]}, {18'd3});
    accept(mat(2, 1), mat(2, 1), 1'b1);
    finish_job(8, 1);
    chk("ones_acc", {hif.res[0][1]}, {18'd6});

    // result held while job_valid waits in DONE
    accept(mat(1, 0), mat(0, 0), 1'b0);
    begin
      int lat;
      lat = 0;
      while (!hif.res_valid && lat < 40) begin
        @(posedge clk); #1; lat++;
      end
      chk("hold_latency", lat, 9);
    end
    chk("hold_res", hif.res, exp_c);
    hif.a_mat     = mat(0, 0);
    hif.b_mat     = mat(0, 0);
    hif.job_acc   = 1'b0;
    hif.job_valid = 1'b1;
    stable = 1'b1;
    jr     = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (hif.res !== exp_c || !hif.res_valid) stable = 1'b0;
      if (hif.job_ready) jr = 1'b1;
    end
    chk("hold_stable", stable, 1);
    chk("hold_no_ready", jr, 0);
    hif.res_ready = 1'b1;
    @(posedge clk); #1;
    hif.res_ready = 1'b0;
    exp_cnt++;
    chk("hold_cnt", hif.job_cnt, exp_cnt);
    chk("first_idle", hif.job_ready, 1);
    model_c = exp_c;
    exp_c   = matmul(mat(0, 0), mat(0, 0), model_c, 1'b0);
    cur_acc = 1'b0;
    clr0    = clr_cnt;
    @(posedge clk); #1;
    hif.job_valid = 1'b0;
    chk("taken_at_once", hif.busy, 1);
    finish_job(9, 0);

    // reset in the middle of FEED (fcnt = 2)
    accept(mat(3, 0), mat(3, 0), 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("mid_reset");
    exp_cnt = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    accept(mat(1, 0), mat(0, 0), 1'b0);
    finish_job(9, 0);

    // random jobs
    have_prev = 1'b1;
    for (int t = 0; t < 16; t++) begin
      bit accum;
      bit early;
      accum = have_prev && ($urandom_range(1) == 1);
      early = ($urandom_range(3) == 0);
      if (early) hif.res_ready = 1'b1;
      accept(mat(3, 0), mat(3, 0), accum);
      finish_job(accum ? 8 : 9, early ? 0 : $urandom_range(3));
    end

    // job counter wraps
    force dut.r_cnt = 16'hFFFF;
    #1 release dut.r_cnt;
    exp_cnt = 16'hFFFF;
    chk("preload", hif.job_cnt, exp_cnt);
    accept(mat(3, 0), mat(3, 0), 1'b0);
    finish_job(9, 0);
    chk("wrapped", hif.job_cnt, 0);

    chk("clr_with_data", clr_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
